// File: rtl/dsp_logic_pkg.sv
// dsp_logic_pkg
//   Shared definitions for the DSP48E2 logic pipe.
//   - op_t        : 3-bit operation code seen on the op port.
//   - ALU_*       : ALUMODE values used by the logic unit.
//   - OPM_*       : OPMODE field values (W[8:7], Z[6:4], Y[3:2], X[1:0]).
//   - dsp_ctrl_t  : {alumode, opmode} pair loaded into the DSP control registers.
//   - op_to_ctrl  : translate (op, acc) into that pair.
package dsp_logic_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_XNOR = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  // Logic-unit ALUMODE codes. With Y=0 they give XOR/XNOR/AND/AND-NOT/NAND;
  // with Y=all-ones the AND and NAND codes turn into OR and NOR.
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_XNOR = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b1100;
  localparam logic [3:0] ALU_ANDN = 4'b1101;
  localparam logic [3:0] ALU_NAND = 4'b1110;

  localparam logic [1:0] OPM_W_ZERO = 2'b00;
  localparam logic [2:0] OPM_Z_ZERO = 3'b000;
  localparam logic [2:0] OPM_Z_P    = 3'b010;
  localparam logic [2:0] OPM_Z_C    = 3'b011;
  localparam logic [1:0] OPM_Y_ZERO = 2'b00;
  localparam logic [1:0] OPM_Y_ONES = 2'b10;
  localparam logic [1:0] OPM_X_AB   = 2'b11;

  typedef struct packed {
    logic [3:0] alumode;
    logic [8:0] opmode;
  } dsp_ctrl_t;

  function automatic dsp_ctrl_t op_to_ctrl(op_t op, logic acc);
    dsp_ctrl_t  ctrl;
    logic [2:0] z_sel;
    logic [1:0] y_sel;
    z_sel        = acc ? OPM_Z_P : OPM_Z_C;
    y_sel        = OPM_Y_ZERO;
    ctrl.alumode = ALU_AND;
    case (op)
      OP_AND:  ctrl.alumode = ALU_AND;
      OP_OR: begin
        ctrl.alumode = ALU_AND;
        y_sel        = OPM_Y_ONES;
      end
      OP_XOR:  ctrl.alumode = ALU_XOR;
      OP_XNOR: ctrl.alumode = ALU_XNOR;
      OP_NAND: ctrl.alumode = ALU_NAND;
      OP_NOR: begin
        ctrl.alumode = ALU_NAND;
        y_sel        = OPM_Y_ONES;
      end
      OP_ANDN: ctrl.alumode = ALU_ANDN;
      // PASS is X OR 0: Z is forced to zero so neither b nor P leaks through.
      OP_PASS: begin
        ctrl.alumode = ALU_AND;
        y_sel        = OPM_Y_ONES;
        z_sel        = OPM_Z_ZERO;
      end
      default: ctrl.alumode = ALU_AND;
    endcase
    ctrl.opmode = {OPM_W_ZERO, z_sel, y_sel, OPM_X_AB};
    return ctrl;
  endfunction

endpackage

// File: rtl/DSP48E2.sv
// DSP48E2 (behavioural stand-in)
//   Cycle model of the DSP48E2 slice restricted to the configuration the logic
//   pipe uses: A:B on X, C/P/0 on Z, Y = 0 or all-ones, W = 0, every input
//   register and P registered, no multiplier, ONE48 SIMD. Leave this file out of
//   the implementation source list so the vendor primitive binds instead.
//   Ports: CLK; A[29:0], B[17:0], C[47:0]; ALUMODE[3:0], OPMODE[8:0];
//   clock enables CEA2/CEB2/CEC/CEALUMODE/CECTRL/CEP; resets RSTA/RSTB/RSTC/
//   RSTALUMODE/RSTCTRL/RSTP; result P[47:0].
module DSP48E2 #(
  parameter int    AREG               = 1,
  parameter int    BREG               = 1,
  parameter int    CREG               = 1,
  parameter int    PREG               = 1,
  parameter int    ALUMODEREG         = 1,
  parameter int    OPMODEREG          = 1,
  parameter int    MREG               = 0,
  parameter int    ADREG              = 0,
  parameter int    DREG               = 0,
  parameter string USE_MULT           = "NONE",
  parameter string USE_SIMD           = "ONE48",
  parameter string USE_PATTERN_DETECT = "NO_PATDET"
) (
  input  logic        CLK,
  input  logic [29:0] A,
  input  logic [17:0] B,
  input  logic [47:0] C,
  input  logic [3:0]  ALUMODE,
  input  logic [8:0]  OPMODE,
  input  logic        CEA2,
  input  logic        CEB2,
  input  logic        CEC,
  input  logic        CEALUMODE,
  input  logic        CECTRL,
  input  logic        CEP,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTC,
  input  logic        RSTALUMODE,
  input  logic        RSTCTRL,
  input  logic        RSTP,
  output logic [47:0] P
);

  if (AREG != 1 || BREG != 1 || CREG != 1 || PREG != 1 ||
      ALUMODEREG != 1 || OPMODEREG != 1 ||
      MREG != 0 || ADREG != 0 || DREG != 0 ||
      USE_MULT != "NONE" || USE_SIMD != "ONE48" ||
      USE_PATTERN_DETECT != "NO_PATDET") begin : g_unsupported
    $error("DSP48E2 stand-in only models the registered logic-unit configuration");
  end

  logic [29:0] a_reg;
  logic [17:0] b_reg;
  logic [47:0] c_reg;
  logic [3:0]  alumode_reg;
  logic [8:0]  opmode_reg;
  logic [47:0] p_reg, p_next;
  logic [47:0] x_mux, z_mux;

  always_ff @(posedge CLK) begin
    if (RSTA) a_reg <= '0;
    else if (CEA2) a_reg <= A;
    if (RSTB) b_reg <= '0;
    else if (CEB2) b_reg <= B;
    if (RSTC) c_reg <= '0;
    else if (CEC) c_reg <= C;
    if (RSTALUMODE) alumode_reg <= '0;
    else if (CEALUMODE) alumode_reg <= ALUMODE;
    if (RSTCTRL) opmode_reg <= '0;
    else if (CECTRL) opmode_reg <= OPMODE;
    if (RSTP) p_reg <= '0;
    else if (CEP) p_reg <= p_next;
  end

  always_comb begin
    x_mux = (opmode_reg[1:0] == 2'b11) ? {a_reg, b_reg} : 48'd0;
    case (opmode_reg[6:4])
      3'b010:  z_mux = p_reg;   // P feedback is combinational into the ALU
      3'b011:  z_mux = c_reg;
      default: z_mux = 48'd0;
    endcase
    p_next = 48'd0;
    // Logic-unit truth table; W must be zero for logic operation.
    if (opmode_reg[8:7] == 2'b00) begin
      case ({opmode_reg[3:2], alumode_reg})
        6'b00_0100: p_next = x_mux ^ z_mux;
        6'b00_0101: p_next = ~(x_mux ^ z_mux);
        6'b00_1100: p_next = x_mux & z_mux;
        6'b00_1101: p_next = x_mux & ~z_mux;
        6'b00_1110: p_next = ~(x_mux & z_mux);
        6'b00_1111: p_next = ~x_mux | z_mux;
        6'b10_0100: p_next = ~(x_mux ^ z_mux);
        6'b10_0101: p_next = x_mux ^ z_mux;
        6'b10_1100: p_next = x_mux | z_mux;
        6'b10_1101: p_next = x_mux | ~z_mux;
        6'b10_1110: p_next = ~(x_mux | z_mux);
        6'b10_1111: p_next = ~x_mux & z_mux;
        default:    p_next = 48'd0;
      endcase
    end
  end

  assign P = p_reg;

endmodule

// File: rtl/dsp_logic_ctrl.sv
// dsp_logic_ctrl
//   Fabric flow control for the two-stage DSP logic pipe.
//   Ports:
//     clock, reset  : clock, synchronous active-high reset
//     in_valid      : upstream beat present
//     out_ready     : downstream takes y
//     in_ready      : pipe accepts a beat this cycle
//     ce_stage1     : enable for A/B/C/ALUMODE/OPMODE registers
//     ce_p          : enable for the P register
//     out_valid     : P holds a result
module dsp_logic_ctrl (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic ce_stage1,
  output logic ce_p,
  output logic out_valid
);

  logic advance;
  logic v1_reg, v1_next;
  logic out_valid_reg, out_valid_next;

  // The whole pipe moves as one unit whenever the output slot is free or drained.
  assign advance   = !out_valid_reg || out_ready;
  assign in_ready  = advance;
  assign ce_stage1 = advance;
  // P only loads real beats, so an accumulated value survives bubbles.
  assign ce_p      = advance && v1_reg;
  assign out_valid = out_valid_reg;

  always_comb begin
    v1_next        = v1_reg;
    out_valid_next = out_valid_reg;
    if (advance) begin
      v1_next        = in_valid;
      out_valid_next = v1_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      v1_reg        <= v1_next;
      out_valid_reg <= out_valid_next;
    end
  end

endmodule

// File: rtl/dsp_logic_pipe.sv
// dsp_logic_pipe
//   Two-stage pipelined bitwise logic unit on one DSP48E2 with runtime op
//   select, valid/ready flow control and an accumulate mode (y = P_prev OP a).
//   Parameters: width (1..48) operand/result width; loc DSP site for LOC.
//   Ports:
//     clock, reset          : clock, synchronous active-high reset
//     in_valid / in_ready   : input handshake
//     op[2:0], acc, a, b    : beat payload (b unused when acc=1)
//     out_valid / out_ready : output handshake
//     y[width-1:0]          : result, low bits of P
module dsp_logic_pipe
  import dsp_logic_pkg::*;
#(
  parameter int width = 48,
  parameter     loc   = "DSP48E2_X0Y0"
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] y
);

  if (width < 1 || width > 48) begin : g_bad_width
    $error("dsp_logic_pipe: width must be in 1..48");
  end
  if ($bits(loc) < 8) begin : g_bad_loc
    $error("dsp_logic_pipe: loc must name a DSP site");
  end

  logic        ce_stage1;
  logic        ce_p;
  dsp_ctrl_t   ctrl;
  logic [47:0] ab_ext;
  logic [47:0] c_ext;
  logic [47:0] p_out;

  assign ctrl = op_to_ctrl(op_t'(op), acc);

  // Zero-extend both operands onto the 48-bit datapath.
  for (genvar gi = 0; gi < 48; gi++) begin : g_ext
    if (gi < width) begin : g_live
      assign ab_ext[gi] = a[gi];
      assign c_ext[gi]  = b[gi];
    end else begin : g_pad
      assign ab_ext[gi] = 1'b0;
      assign c_ext[gi]  = 1'b0;
    end
  end

  dsp_logic_ctrl u_ctrl (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .ce_stage1 (ce_stage1),
    .ce_p      (ce_p),
    .out_valid (out_valid)
  );

  (* LOC = loc *)
  DSP48E2 #(
    .AREG               (1),
    .BREG               (1),
    .CREG               (1),
    .PREG               (1),
    .ALUMODEREG         (1),
    .OPMODEREG          (1),
    .MREG               (0),
    .ADREG              (0),
    .DREG               (0),
    .USE_MULT           ("NONE"),
    .USE_SIMD           ("ONE48"),
    .USE_PATTERN_DETECT ("NO_PATDET")
  ) u_dsp (
    .CLK        (clock),
    .A          (ab_ext[47:18]),
    .B          (ab_ext[17:0]),
    .C          (c_ext),
    .ALUMODE    (ctrl.alumode),
    .OPMODE     (ctrl.opmode),
    .CEA2       (ce_stage1),
    .CEB2       (ce_stage1),
    .CEC        (ce_stage1),
    .CEALUMODE  (ce_stage1),
    .CECTRL     (ce_stage1),
    .CEP        (ce_p),
    .RSTA       (reset),
    .RSTB       (reset),
    .RSTC       (reset),
    .RSTALUMODE (reset),
    .RSTCTRL    (reset),
    .RSTP       (reset),
    .P          (p_out)
  );

  assign y = p_out[width-1:0];

endmodule

// File: tb/tb_dsp_logic_pipe.sv
module tb_dsp_logic_pipe;

  localparam int W      = 16;
  localparam int NBEATS = 10000;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic         acc;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;

  int checks = 0;
  int errors = 0;

  dsp_logic_pipe #(.width(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .acc       (acc),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clock = ~clock;

  // Reference: the operation table applied to plain integers.
  function automatic logic [W-1:0] ref_op(input logic [2:0] code, input logic [W-1:0] x,
                                          input logic [W-1:0] z);
    case (code)
      3'd0:    return x & z;
      3'd1:    return x | z;
      3'd2:    return x ^ z;
      3'd3:    return ~(x ^ z);
      3'd4:    return ~(x & z);
      3'd5:    return ~(x | z);
      3'd6:    return x & ~z;
      default: return x;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic ac,
                       input logic [W-1:0] av, input logic [W-1:0] bv);
    in_valid = v;
    op       = o;
    acc      = ac;
    a        = av;
    b        = bv;
  endtask

  task automatic test_reset();
    drive(1'b0, 3'd0, 1'b0, '0, '0);
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (y !== '0) begin
      errors++;
      $display("FAIL reset_y got %h want 0000", y);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    $display("reset: out_valid=%b y=%h in_ready=%b", out_valid, y, in_ready);
  endtask

  task automatic test_two_beats();
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 1'b0, 16'h00F0, 16'h0F0F);
    tick();
    drive(1'b1, 3'd0, 1'b0, 16'hFFFF, 16'h1234);
    tick();
    drive(1'b0, 3'd0, 1'b0, '0, '0);
    checks++;
    if (out_valid !== 1'b1 || y !== 16'h0FFF) begin
      errors++;
      $display("FAIL two_beats_first got v=%b y=%h want v=1 y=0fff", out_valid, y);
    end
    $display("two_beats: OR  y=%h", y);
    tick();
    checks++;
    if (out_valid !== 1'b1 || y !== 16'h1234) begin
      errors++;
      $display("FAIL two_beats_second got v=%b y=%h want v=1 y=1234", out_valid, y);
    end
    $display("two_beats: AND y=%h", y);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_beats_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_all_ops();
    logic [W-1:0] expv [8];
    expv = '{16'h05C0, 16'hAFF3, 16'hAA33, 16'h55CC, 16'hFA3F, 16'h500C, 16'hA003, 16'hA5C3};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, 3'(i), 1'b0, 16'hA5C3, 16'h0FF0);
      else       drive(1'b0, 3'd0, 1'b0, '0, '0);
      tick();
      if (i >= 1 && i <= 8) begin
        checks++;
        if (out_valid !== 1'b1 || y !== expv[i-1]) begin
          errors++;
          $display("FAIL all_ops_op%0d got v=%b y=%h want v=1 y=%h", i - 1, out_valid, y, expv[i-1]);
        end
        $display("all_ops: op=%0d y=%h", i - 1, y);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [W-1:0] expv [3];
    logic [W-1:0] av   [3];
    expv = '{16'h0001, 16'h0002, 16'h0006};
    av   = '{16'h0001, 16'h0003, 16'h0004};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0)     drive(1'b1, 3'd7, 1'b0, av[0], 16'hBEEF);
      else if (i < 3) drive(1'b1, 3'd2, 1'b1, av[i], 16'hFFFF);
      else            drive(1'b0, 3'd0, 1'b0, '0, '0);
      tick();
      if (i >= 1 && i <= 3) begin
        checks++;
        if (out_valid !== 1'b1 || y !== expv[i-1]) begin
          errors++;
          $display("FAIL accumulate_%0d got v=%b y=%h want v=1 y=%h", i - 1, out_valid, y, expv[i-1]);
        end
        $display("accumulate: step=%0d y=%h", i - 1, y);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    logic [2:0]   ov [3];
    logic [W-1:0] e  [3];
    ov = '{3'd2, 3'd4, 3'd6};
    for (int i = 0; i < 3; i++) begin
      av[i] = W'($urandom);
      bv[i] = W'($urandom);
      e[i]  = ref_op(ov[i], av[i], bv[i]);
    end
    out_ready = 1'b0;
    drive(1'b1, ov[0], 1'b0, av[0], bv[0]);
    tick();
    drive(1'b1, ov[1], 1'b0, av[1], bv[1]);
    tick();
    drive(1'b1, ov[2], 1'b0, av[2], bv[2]);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== e[0]) begin
        errors++;
        $display("FAIL stall_hold%0d got rdy=%b v=%b y=%h want rdy=0 v=1 y=%h",
                 k, in_ready, out_valid, y, e[0]);
      end
      $display("stall: cycle=%0d y=%h", k, y);
      tick();
    end
    out_ready = 1'b1;
    tick();
    drive(1'b0, 3'd0, 1'b0, '0, '0);
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || y !== e[i]) begin
        errors++;
        $display("FAIL stall_release%0d got v=%b y=%h want v=1 y=%h", i, out_valid, y, e[i]);
      end
      $display("stall: release beat=%0d y=%h", i, y);
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 1'b0, 16'h1357, 16'h2468);
    tick();
    drive(1'b1, 3'd2, 1'b0, 16'h5555, 16'h0F0F);
    tick();
    drive(1'b0, 3'd0, 1'b0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state got v=%b y=%h rdy=%b want v=0 y=0000 rdy=1", out_valid, y, in_ready);
    end
    drive(1'b1, 3'd2, 1'b1, 16'h00FF, 16'hA5A5);
    tick();
    drive(1'b0, 3'd0, 1'b0, '0, '0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || y !== 16'h00FF) begin
      errors++;
      $display("FAIL midreset_acc got v=%b y=%h want v=1 y=00ff", out_valid, y);
    end
    $display("reset_midstream: acc xor y=%h", y);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_ghost got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] p_model;
    logic [W-1:0] e;
    int sent = 0;
    int received = 0;
    bit fire, take;
    drive(1'b0, 3'd0, 1'b0, '0, '0);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    p_model = '0;
    for (int cyc = 0; cyc < 60000 && received < NBEATS; cyc++) begin
      in_valid  = (sent < NBEATS) && ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      acc       = ($urandom_range(0, 2) == 0);
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      fire = in_valid && in_ready;
      take = out_valid && out_ready;
      if (take) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL random_extra got y=%h want no output", y);
        end else begin
          e = exp_q.pop_front();
          if (y !== e) begin
            errors++;
            $display("FAIL random_beat%0d got y=%h want %h", received, y, e);
          end
          $display("random: beat=%0d y=%h", received, y);
          received++;
        end
      end
      if (fire) begin
        p_model = ref_op(op, a, acc ? p_model : b);
        exp_q.push_back(p_model);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (received != NBEATS || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_count got %0d received (%0d pending) want %0d", received, exp_q.size(), NBEATS);
    end
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 1'b0, '0, '0);
    test_reset();
    test_two_beats();
    test_all_ops();
    test_accumulate();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
